opti_result_buf: RTL

Capture buffer directly downstream of opti_top. It stores one filtered frame of 2048 samples: data_out, written at addr, whenever data_out_valid is high. After filter_done it drains the frame in address order over a valid/ready stream for readback and checking. It also keeps per-frame statistics: sample count, peak magnitude, stability and error flags.

---
 rtl/opti_result_buf_if.sv | 45 ++++
 rtl/opti_result_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/opti_result_buf_if.sv
// Bus bundle for opti_result_buf: capture side (from opti_top), readback
// stream, frame statistics and a debug view of the controller state.
//
// Readback handshake: a beat transfers on a rising clk edge where
// rd_valid && rd_ready. Once rd_valid is high it stays high, and rd_data,
// rd_addr and rd_last stay unchanged, until that beat transfers; rd_valid
// never depends combinationally on rd_ready. The only exceptions are start
// and rst, which abort the stream.
//
// state_dbg encoding: 0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE.
interface opti_result_buf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] din_addr;
    logic              din_valid;
    logic              din_done;
    logic              stable_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              busy;
    logic [ADDR_W:0]   cap_count;
    logic [DATA_W-1:0] peak_abs;
    logic              unstable_flag;
    logic              addr_err;
    logic              overrun_err;
    logic [1:0]        state_dbg;

    modport slave (
        input  start, din, din_addr, din_valid, din_done, stable_in, rd_ready,
        output rd_valid, rd_data, rd_addr, rd_last, busy, cap_count, peak_abs,
               unstable_flag, addr_err, overrun_err, state_dbg
    );

    modport master (
        output start, din, din_addr, din_valid, din_done, stable_in, rd_ready,
        input  rd_valid, rd_data, rd_addr, rd_last, busy, cap_count, peak_abs,
               unstable_flag, addr_err, overrun_err, state_dbg
    );
endinterface

// File: rtl/opti_result_buf.sv
// Frame capture buffer behind opti_top: stores one frame of samples at the
// addresses opti_top supplies, gathers per-frame statistics, then drains the
// frame in address order over a valid/ready stream. The drain path uses a
// synchronous RAM read feeding an output register plus one skid register so
// that a full-rate stream has no bubbles and stalls never lose a sample.
module opti_result_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic             clk,
    input  logic             rst,
    opti_result_buf_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cap_count_q, cap_count_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              unstable_q, unstable_d;
    logic              addr_err_q, addr_err_d;
    logic              overrun_q, overrun_d;
    // Next index to fetch from RAM.
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    // A RAM read was issued last cycle; ram_q holds its data now.
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    // Output register (what the stream presents).
    logic              out_v_q, out_v_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    // Skid register: catches a fetched sample while the output is stalled.
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic              skid_last_q, skid_last_d;

    logic              wr_en;
    logic              rd_en;
    logic              fire;
    logic [DATA_W-1:0] din_abs;
    logic [1:0]        occ;
    logic [ADDR_W:0]   last_idx;
    logic              pend_last;

    // Sample storage: capture writes and drain reads (1-cycle read latency).
    always_ff @(posedge clk) begin
        if (wr_en) mem[bus.din_addr] <= bus.din;
        if (rd_en) ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end

    // Controller and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cap_count_q <= '0;
            peak_q      <= '0;
            unstable_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_count_q <= cap_count_d;
            peak_q      <= peak_d;
            unstable_q  <= unstable_d;
            addr_err_q  <= addr_err_d;
            overrun_q   <= overrun_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_addr_q <= skid_addr_d;
            skid_last_q <= skid_last_d;
        end
    end

    // Next-state, capture bookkeeping and drain pipeline steering.
    always_comb begin
        state_d     = state_q;
        cap_count_d = cap_count_q;
        peak_d      = peak_q;
        unstable_d  = unstable_q;
        addr_err_d  = addr_err_q;
        overrun_d   = overrun_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_addr_d = skid_addr_q;
        skid_last_d = skid_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        fire      = out_v_q & bus.rd_ready;
        // Unsigned magnitude: the most negative value maps to itself, which
        // read as unsigned is exactly its magnitude.
        din_abs   = bus.din[DATA_W-1] ? (~bus.din + DATA_ONE) : bus.din;
        // Samples held or in flight once this cycle's transfer is taken out.
        occ       = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q} - {1'b0, fire};
        last_idx  = cap_count_q - CNT_ONE;
        pend_last = ({1'b0, pend_addr_q} == last_idx);

        case (state_q)
            S_CAPTURE: begin
                if (bus.din_valid) begin
                    wr_en       = 1'b1;
                    cap_count_d = cap_count_q + CNT_ONE;
                    if (bus.din_addr != cap_count_q[ADDR_W-1:0]) addr_err_d = 1'b1;
                    if (din_abs > peak_q) peak_d = din_abs;
                    if (!bus.stable_in) unstable_d = 1'b1;
                end
                if (bus.din_done || (bus.din_valid && cap_count_d == CNT_FULL)) begin
                    state_d  = S_DRAIN;
                    rd_ptr_d = '0;
                    pend_d   = 1'b0;
                    out_v_d  = 1'b0;
                    skid_v_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (bus.din_valid) overrun_d = 1'b1;
                if (cap_count_q == '0) begin
                    state_d = S_DONE;
                end else if (fire && out_last_q) begin
                    state_d  = S_DONE;
                    out_v_d  = 1'b0;
                    skid_v_d = 1'b0;
                    pend_d   = 1'b0;
                end else begin
                    if (fire) out_v_d = 1'b0;
                    if (skid_v_q && !out_v_d) begin
                        out_v_d    = 1'b1;
                        out_data_d = skid_data_q;
                        out_addr_d = skid_addr_q;
                        out_last_d = skid_last_q;
                        skid_v_d   = 1'b0;
                    end
                    if (pend_q) begin
                        if (!out_v_d) begin
                            out_v_d    = 1'b1;
                            out_data_d = ram_q;
                            out_addr_d = pend_addr_q;
                            out_last_d = pend_last;
                        end else begin
                            skid_v_d    = 1'b1;
                            skid_data_d = ram_q;
                            skid_addr_d = pend_addr_q;
                            skid_last_d = pend_last;
                        end
                    end
                    // Fetch only when the sample is guaranteed a register.
                    if (rd_ptr_q < cap_count_q && occ < 2'd2) begin
                        rd_en       = 1'b1;
                        pend_d      = 1'b1;
                        pend_addr_d = rd_ptr_q[ADDR_W-1:0];
                        rd_ptr_d    = rd_ptr_q + CNT_ONE;
                    end else begin
                        pend_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // start overrides everything: rearm capture and abort any drain.
        if (bus.start) begin
            state_d     = S_CAPTURE;
            cap_count_d = '0;
            peak_d      = '0;
            unstable_d  = 1'b0;
            addr_err_d  = 1'b0;
            overrun_d   = 1'b0;
            rd_ptr_d    = '0;
            pend_d      = 1'b0;
            out_v_d     = 1'b0;
            skid_v_d    = 1'b0;
            wr_en       = 1'b0;
            rd_en       = 1'b0;
        end
    end

    assign bus.rd_valid      = out_v_q;
    assign bus.rd_data       = out_data_q;
    assign bus.rd_addr       = out_addr_q;
    assign bus.rd_last       = out_last_q;
    assign bus.busy          = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign bus.cap_count     = cap_count_q;
    assign bus.peak_abs      = peak_q;
    assign bus.unstable_flag = unstable_q;
    assign bus.addr_err      = addr_err_q;
    assign bus.overrun_err   = overrun_q;
    assign bus.state_dbg     = state_q;
endmodule
